parking_ctrl: RTL and testbench

PARKING_CTRL -- requirements
Module: Parking

---
 rtl/parking_ctrl.sv | 111 +++++++++++
 tb/tb_parking_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl.sv
// ============================================================================
//  Module      : parking_ctrl
//  Description : Two-class (university / general) parking lot occupancy
//                controller with optional time-of-day capacity split,
//                enabled by defining PARKING_TIMED_CAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parking_ctrl #(
    parameter int CYCLES_PER_HOUR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ci,
    input  logic        uci,
    input  logic        ce,
    input  logic        uce,
    output logic [10:0] upc,
    output logic [10:0] pc,
    output logic [10:0] uvs,
    output logic [10:0] vs,
    output logic        uivs,
    output logic        ivs
);

    localparam logic [10:0] c_TOTAL    = 11'd700;
    localparam logic [10:0] c_UCAP_DAY = 11'd500;

    logic [10:0] r_upc;
    logic [10:0] r_pc;
    logic        r_uivs;
    logic        r_ivs;

    logic [10:0] w_ucap;
    logic [10:0] w_gcap;
    logic [10:0] w_uvs;
    logic [10:0] w_vs;
    logic        w_uin;
    logic        w_uout;
    logic        w_gin;
    logic        w_gout;

`ifdef PARKING_TIMED_CAP_EN
    localparam int              c_PW   = (CYCLES_PER_HOUR > 1) ? $clog2(CYCLES_PER_HOUR) : 1;
    localparam logic [c_PW-1:0] c_PMAX = c_PW'(CYCLES_PER_HOUR - 1);

    logic [c_PW-1:0] r_presc;
    logic [4:0]      r_hour;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_hour  <= 5'd8;
        end else if (r_presc == c_PMAX) begin
            r_presc <= '0;
            r_hour  <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // University share shrinks through the afternoon, general share grows
    always_comb begin
        w_ucap = c_UCAP_DAY;
        if (r_hour >= 5'd15)
            w_ucap = 11'd200;
        else if (r_hour == 5'd14)
            w_ucap = 11'd300;
        else if (r_hour == 5'd13)
            w_ucap = 11'd400;
    end
`else
    assign w_ucap = c_UCAP_DAY;
`endif

    assign w_gcap = c_TOTAL - w_ucap;

    // Saturate at zero: a capacity drop may leave more cars than spaces
    assign w_uvs = (r_upc >= w_ucap) ? 11'd0 : w_ucap - r_upc;
    assign w_vs  = (r_pc  >= w_gcap) ? 11'd0 : w_gcap - r_pc;

    assign w_uin  = uci & (w_uvs != 11'd0);
    assign w_uout = uce & (r_upc != 11'd0);
    assign w_gin  = ci  & (w_vs  != 11'd0);
    assign w_gout = ce  & (r_pc  != 11'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upc  <= 11'd0;
            r_pc   <= 11'd0;
            r_uivs <= 1'b0;
            r_ivs  <= 1'b0;
        end else begin
            r_upc  <= r_upc + {10'd0, w_uin} - {10'd0, w_uout};
            r_pc   <= r_pc  + {10'd0, w_gin} - {10'd0, w_gout};
            r_uivs <= (uci & ~w_uin) | (uce & ~w_uout);
            r_ivs  <= (ci  & ~w_gin) | (ce  & ~w_gout);
        end
    end

    assign upc  = r_upc;
    assign pc   = r_pc;
    assign uvs  = w_uvs;
    assign vs   = w_vs;
    assign uivs = r_uivs;
    assign ivs  = r_ivs;

endmodule

`default_nettype wire

// File: tb/tb_parking_ctrl.sv
// ============================================================================
//  Module      : tb_parking_ctrl
//  Description : Self-checking bench for parking_ctrl; reference model tracks
//                counts and derives the hour from elapsed cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parking_ctrl;

`ifdef PARKING_TIMED_CAP_EN
    localparam int TB_CPH = 1;
`else
    localparam int TB_CPH = 4;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ci  = 1'b0;
    logic        uci = 1'b0;
    logic        ce  = 1'b0;
    logic        uce = 1'b0;
    logic [10:0] upc;
    logic [10:0] pc;
    logic [10:0] uvs;
    logic [10:0] vs;
    logic        uivs;
    logic        ivs;

    int   n_tests = 0;
    int   n_fail  = 0;

    int   m_upc   = 0;
    int   m_pc    = 0;
    int   m_edges = 0;
    logic m_uivs  = 1'b0;
    logic m_ivs   = 1'b0;

    parking_ctrl #(.CYCLES_PER_HOUR(TB_CPH)) dut (
        .clk  (clk),
        .rst  (rst),
        .ci   (ci),
        .uci  (uci),
        .ce   (ce),
        .uce  (uce),
        .upc  (upc),
        .pc   (pc),
        .uvs  (uvs),
        .vs   (vs),
        .uivs (uivs),
        .ivs  (ivs)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------------
    // Reference model: hour is elapsed time since reset, not a counter
    // ------------------------------------------------------------------
`ifdef PARKING_TIMED_CAP_EN
    function automatic int hour_now();
        return (8 + m_edges / TB_CPH) % 24;
    endfunction
`endif

    function automatic int ucap_now();
`ifdef PARKING_TIMED_CAP_EN
        int h = hour_now();
        if (h >= 15) return 200;
        if (h == 14) return 300;
        if (h == 13) return 400;
        return 500;
`else
        return 500;
`endif
    endfunction

    function automatic int uvs_now();
        return (m_upc >= ucap_now()) ? 0 : ucap_now() - m_upc;
    endfunction

    function automatic int vs_now();
        int g = 700 - ucap_now();
        return (m_pc >= g) ? 0 : g - m_pc;
    endfunction

    task automatic model_step(input logic a_ci, input logic a_uci, input logic a_ce, input logic a_uce);
        logic ua, ux, ga, gx;
        ua = a_uci && (uvs_now() > 0);
        ux = a_uce && (m_upc > 0);
        ga = a_ci  && (vs_now() > 0);
        gx = a_ce  && (m_pc > 0);
        m_uivs = (a_uci && !ua) || (a_uce && !ux);
        m_ivs  = (a_ci  && !ga) || (a_ce  && !gx);
        m_upc  = m_upc + (ua ? 1 : 0) - (ux ? 1 : 0);
        m_pc   = m_pc  + (ga ? 1 : 0) - (gx ? 1 : 0);
        m_edges++;
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic step(input logic a_ci, input logic a_uci, input logic a_ce, input logic a_uce);
        ci = a_ci; uci = a_uci; ce = a_ce; uce = a_uce;
        model_step(a_ci, a_uci, a_ce, a_uce);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        ci = 0; uci = 0; ce = 0; uce = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_upc = 0; m_pc = 0; m_edges = 0; m_uivs = 1'b0; m_ivs = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        repeat (3) step(0, 0, 0, 0);
        n_tests++; if (upc !== 11'd0)   begin n_fail++; $display("FAIL reset_upc got %0d exp 0", upc); end
        n_tests++; if (pc !== 11'd0)    begin n_fail++; $display("FAIL reset_pc got %0d exp 0", pc); end
        n_tests++; if (uvs !== 11'd500) begin n_fail++; $display("FAIL reset_uvs got %0d exp 500", uvs); end
        n_tests++; if (vs !== 11'd200)  begin n_fail++; $display("FAIL reset_vs got %0d exp 200", vs); end
        n_tests++; if (uivs !== 1'b0)   begin n_fail++; $display("FAIL reset_uivs got %0b exp 0", uivs); end
        n_tests++; if (ivs !== 1'b0)    begin n_fail++; $display("FAIL reset_ivs got %0b exp 0", ivs); end
    endtask

    task automatic test_fill_drain();
        int pulses = 0;
        do_reset();
        repeat (6) step(1, 0, 0, 0);
        n_tests++; if (pc !== 11'd6) begin n_fail++; $display("FAIL fd_pc6 got %0d exp 6", pc); end
        n_tests++; if (vs !== 11'(vs_now())) begin n_fail++; $display("FAIL fd_vs got %0d exp %0d", vs, vs_now()); end
`ifndef PARKING_TIMED_CAP_EN
        n_tests++; if (vs !== 11'd194) begin n_fail++; $display("FAIL fd_vs194 got %0d exp 194", vs); end
`endif
        n_tests++; if (ivs !== 1'b0) begin n_fail++; $display("FAIL fd_ivs0 got %0b exp 0", ivs); end
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 0);
            if (ivs === 1'b1) pulses++;
            n_tests++; if (ivs !== m_ivs) begin n_fail++; $display("FAIL fd_ivs_exit%0d got %0b exp %0b", i, ivs, m_ivs); end
        end
        n_tests++; if (pc !== 11'd0) begin n_fail++; $display("FAIL fd_pc0 got %0d exp 0", pc); end
        n_tests++; if (pulses != 2) begin n_fail++; $display("FAIL fd_pulses got %0d exp 2", pulses); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (5) step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1, 0);
            n_tests++; if (pc !== 11'd5) begin n_fail++; $display("FAIL sim_pc%0d got %0d exp 5", i, pc); end
            n_tests++; if (ivs !== 1'b0) begin n_fail++; $display("FAIL sim_ivs%0d got %0b exp 0", i, ivs); end
        end
    endtask

    task automatic test_general_full();
        int k = 0;
        do_reset();
        while (m_pc < 200 && k < 2000) begin step(1, 0, 0, 0); k++; end
        n_tests++; if (pc !== 11'd200) begin n_fail++; $display("FAIL full_pc got %0d exp 200", pc); end
        n_tests++; if (vs !== 11'(vs_now())) begin n_fail++; $display("FAIL full_vs got %0d exp %0d", vs, vs_now()); end
`ifndef PARKING_TIMED_CAP_EN
        n_tests++; if (vs !== 11'd0) begin n_fail++; $display("FAIL full_vs0 got %0d exp 0", vs); end
`endif
        step(1, 0, 0, 0);
        n_tests++; if (ivs !== m_ivs) begin n_fail++; $display("FAIL full_ivs got %0b exp %0b", ivs, m_ivs); end
        n_tests++; if (pc !== 11'(m_pc)) begin n_fail++; $display("FAIL full_pc_after got %0d exp %0d", pc, m_pc); end
`ifndef PARKING_TIMED_CAP_EN
        n_tests++; if (ivs !== 1'b1 || pc !== 11'd200) begin n_fail++; $display("FAIL full_reject got ivs=%0b pc=%0d exp ivs=1 pc=200", ivs, pc); end
`endif
    endtask

`ifdef PARKING_TIMED_CAP_EN
    task automatic test_timed_cap();
        int k = 0;
        do_reset();
        while ((m_upc < 450 || m_pc < 200) && k < 5000) begin
            step(m_pc < 200, m_upc < 450, 0, 0);
            k++;
        end
        n_tests++; if (upc !== 11'd450) begin n_fail++; $display("FAIL tc_fill_upc got %0d exp 450", upc); end
        k = 0;
        while (hour_now() != 15 && k < 30) begin step(0, 0, 0, 0); k++; end
        n_tests++; if (hour_now() != 15) begin n_fail++; $display("FAIL tc_hour15 bound expired, hour %0d exp 15", hour_now()); end
        n_tests++; if (uvs !== 11'd0)   begin n_fail++; $display("FAIL tc_uvs got %0d exp 0", uvs); end
        n_tests++; if (upc !== 11'd450) begin n_fail++; $display("FAIL tc_upc got %0d exp 450", upc); end
        n_tests++; if (pc !== 11'd200)  begin n_fail++; $display("FAIL tc_pc got %0d exp 200", pc); end
        n_tests++; if (vs !== 11'd300)  begin n_fail++; $display("FAIL tc_vs got %0d exp 300", vs); end
        step(0, 1, 0, 0);
        n_tests++; if (uivs !== 1'b1)   begin n_fail++; $display("FAIL tc_uivs got %0b exp 1", uivs); end
        n_tests++; if (upc !== 11'd450) begin n_fail++; $display("FAIL tc_upc_after got %0d exp 450", upc); end
        step(0, 0, 0, 0);
        n_tests++; if (uivs !== 1'b0)   begin n_fail++; $display("FAIL tc_uivs_clear got %0b exp 0", uivs); end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3);
            n_tests++; if (upc !== 11'(m_upc)) begin n_fail++; $display("FAIL rnd_upc cyc %0d got %0d exp %0d", i, upc, m_upc); end
            n_tests++; if (pc !== 11'(m_pc))   begin n_fail++; $display("FAIL rnd_pc cyc %0d got %0d exp %0d", i, pc, m_pc); end
            n_tests++; if (uvs !== 11'(uvs_now())) begin n_fail++; $display("FAIL rnd_uvs cyc %0d got %0d exp %0d", i, uvs, uvs_now()); end
            n_tests++; if (vs !== 11'(vs_now()))   begin n_fail++; $display("FAIL rnd_vs cyc %0d got %0d exp %0d", i, vs, vs_now()); end
            n_tests++; if (uivs !== m_uivs) begin n_fail++; $display("FAIL rnd_uivs cyc %0d got %0b exp %0b", i, uivs, m_uivs); end
            n_tests++; if (ivs !== m_ivs)   begin n_fail++; $display("FAIL rnd_ivs cyc %0d got %0b exp %0b", i, ivs, m_ivs); end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (20) step(1, 1, 0, 0);
        n_tests++; if (pc !== 11'd20 || upc !== 11'd20) begin n_fail++; $display("FAIL ar_pre got pc=%0d upc=%0d exp 20/20", pc, upc); end
        step(0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (upc !== 11'd0)   begin n_fail++; $display("FAIL ar_upc got %0d exp 0", upc); end
        n_tests++; if (pc !== 11'd0)    begin n_fail++; $display("FAIL ar_pc got %0d exp 0", pc); end
        n_tests++; if (uvs !== 11'd500) begin n_fail++; $display("FAIL ar_uvs got %0d exp 500", uvs); end
        n_tests++; if (vs !== 11'd200)  begin n_fail++; $display("FAIL ar_vs got %0d exp 200", vs); end
        n_tests++; if (uivs !== 1'b0 || ivs !== 1'b0) begin n_fail++; $display("FAIL ar_flags got uivs=%0b ivs=%0b exp 0/0", uivs, ivs); end
        ci = 1; uci = 1; ce = 0; uce = 1;
        @(posedge clk);
        @(negedge clk);
        n_tests++; if (upc !== 11'd0 || pc !== 11'd0) begin n_fail++; $display("FAIL ar_hold got upc=%0d pc=%0d exp 0/0", upc, pc); end
        n_tests++; if (uivs !== 1'b0) begin n_fail++; $display("FAIL ar_hold_uivs got %0b exp 0", uivs); end
        ci = 0; uci = 0; ce = 0; uce = 0;
        rst = 1'b0;
        m_upc = 0; m_pc = 0; m_edges = 0; m_uivs = 1'b0; m_ivs = 1'b0;
        step(0, 1, 0, 0);
        n_tests++; if (upc !== 11'd1) begin n_fail++; $display("FAIL ar_resume got %0d exp 1", upc); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_simultaneous();
        test_general_full();
`ifdef PARKING_TIMED_CAP_EN
        test_timed_cap();
`endif
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
